i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (slave) controller answering a 7-bit bus address on a shared SCL/SDA pair; the responder counterpart to the SoC's `i2c_master`, used in loopback benches and wherever the controller itself is exposed to an external host. It oversamples the bus on the system clock, detects START/STOP, matches the address, ACKs, delivers written bytes to the fabric and serves read bytes from it. It has no clock stretching: SCL is input-only and SDA is only ever pulled low.

## Interface
- `FILTER_LEN`, default 3: SCL/SDA glitch-filter depth in clk cycles; used only with the filter macro.
- `clk` in, 1: system clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `own_addr` in, 7: target address. Must be static while the block is not in IDLE.
- `tx_data` in, 8: read-byte source. Captured as described under Operation.
- `rx_data` out, 8: last written byte. Reset 0.
- `rx_valid` out, 1: one-cycle pulse when `rx_data` updates. Reset 0.
- `tx_req` out, 1: one-cycle pulse requesting the next `tx_data`. Reset 0.
- `busy` out, 1: high from an address match to STOP, repeated START or NACK. Reset 0.
- `rw` out, 1: R/W bit of the last matched address (1 = read). Reset 0.
- `start_det`, `stop_det` out, 1 each: one-cycle pulses on bus START and bus STOP, for any address. Reset 0.
- `scl` inout: input-only, never driven.
- `sda` inout: driven 0 or high-Z only. Reset high-Z.

## Operation
- The bus inputs pass through a 2-flop synchronizer and are then edge-detected.
- **START:** SDA falls while SCL is high. **STOP:** SDA rises while SCL is high. Both are recognised in every state. START or repeated START → ADDR with the bit counter cleared. STOP → IDLE.
- **States:** IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- **Bit timing:** data is sampled on SCL rise. SDA drive changes only on SCL fall.
- **ADDR:** shift 8 bits, MSB first.
  - On the 8th rise, if `[7:1] == own_addr`: latch `rw`, set `busy`, and go to ADDR_ACK. On that SCL fall, drive SDA low.
  - Otherwise go to WAIT_STOP and never drive SDA.
- **ADDR_ACK:**
  - On the next SCL fall, release SDA.
  - Then go to WRITE if `rw = 0`.
  - If `rw = 1`, go to READ, and on that same fall also load `tx_data` and drive its MSB.
  - For reads, `tx_req` pulses on the SCL rise of the ACK slot.
- **WRITE:**
  - After 8 rises, update `rx_data` and pulse `rx_valid` the following cycle.
  - Drive ACK on the next fall, then go to WRITE_ACK.
  - The target always ACKs written bytes.
  - At the end of the ACK slot, release SDA and return to WRITE.
- **READ:**
  - Shift out on each fall. After the 8th bit's fall-out, release SDA on the following fall, then go to READ_ACK.
- **READ_ACK:** sample the host's ACK on SCL rise.
  - ACK (0): pulse `tx_req`. On the next fall, load `tx_data` and go to READ.
  - NACK (1): clear `busy` and go to WAIT_STOP.
- **WAIT_STOP:** SDA is high-Z. Exits only on START or STOP.
- **Reset mid-transfer:** SDA is released immediately (asynchronously), all outputs return to reset values, and the state returns to IDLE.
- **Simultaneous events:** START/STOP detection has priority over any data-bit edge in the same cycle.

## Timing
- Bus-edge to internal-event latency: 3 clk cycles (synchronizer plus edge register), plus `FILTER_LEN` when the filter is enabled.
- SDA drive change: 1 cycle after the internal SCL-fall event.
- Minimum clk requirement: 16× the SCL frequency, so that a 400 kHz bus needs a clk of at least 6.4 MHz.
- `tx_data` must be valid within half an SCL period of `tx_req`.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined:
  - SCL and SDA each pass a `FILTER_LEN`-cycle stability filter after the synchronizer.
  - Pulses shorter than `FILTER_LEN` cycles are ignored.
- Undefined: no filter, and `FILTER_LEN` is unused.

## Structure
- `i2c_target_state_e` and `I2C_TARGET_MIN_OVERSAMPLE = 16` are added to `iot_sensor_pkg`.
- One sub-module, `i2c_bus_sync`, contains the synchronizer, the optional filter and edge/START/STOP detection. It outputs the filtered `scl`/`sda` levels plus `scl_rise`, `scl_fall`, `start`, `stop` pulses.
- The FSM, shifter and SDA driver live in `i2c_target`.

## Test plan
- **Write:** `own_addr` 0x48, host writes address 0x90 then data 0xA5 then STOP → two ACKs on SDA, `rx_valid` once with `rx_data` 0xA5, `rw` 0, then `stop_det`, `busy` 0.
- **Mismatch:** host addresses 0x49 (byte 0x92) and writes 0x11 → SDA never driven, no `rx_valid`, `busy` stays 0, `start_det`/`stop_det` still pulse.
- **Two-byte read:** `tx_data` 0x3C then 0xC3; host reads address 0x91, ACKs byte 1, NACKs byte 2 → bus shows 0x3C then 0xC3, `tx_req` pulses twice, SDA released after the NACK.
- **Repeated START:** write 0x07, then repeated START with read 0x91 → `rx_data` 0x07, `rw` switches to 1, correct read byte returned.
- **Reset mid-transfer:** assert `rst_n` low during bit 4 of a read → SDA high-Z within the reset, all outputs 0; the next transaction works normally.
- **Filter:** with `I2C_TARGET_GLITCH_FILTER_EN`, a 1-cycle SDA low pulse while SCL is high → no `start_det`. Without the macro, the same pulse → `start_det` fires.

Source files
------------

// File: rtl/iot_sensor_pkg.sv
// Shared types for the iot_sensor slice.
// Holds the i2c_target state encoding and bus timing limits.
package iot_sensor_pkg;

    localparam int I2C_TARGET_MIN_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_target_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer, optional glitch filter and START/STOP detect.
// Filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_bus_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    // Two-flop synchronizer; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] scl_cnt;
    logic [CW-1:0] sda_cnt;

    // A level is accepted only after FILTER_LEN stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl     <= 1'b1;
            sda     <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
                scl     <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
                sda     <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    // Edge register; START/STOP need SCL high on both samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_q    <= scl;
            sda_q    <= sda;
            scl_rise <= scl & ~scl_q;
            scl_fall <= ~scl & scl_q;
            start    <= scl & scl_q & sda_q & ~sda;
            stop     <= scl & scl_q & ~sda_q & sda;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, ACK, byte write/read, no stretching.
// Glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import iot_sensor_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] own_addr,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    inout  wire        scl,
    inout  wire        sda
);

    i2c_target_state_e state;

    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       bus_start;
    logic       bus_stop;
    logic       rise_ok;
    logic       fall_ok;
    logic [3:0] bit_cnt;
    logic [6:0] shift;
    logic [6:0] tx_shift;
    logic       sda_oe;

    i2c_bus_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sda),
        .scl     (scl_f),
        .sda     (sda_f),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (bus_start),
        .stop    (bus_stop)
    );

    // An edge counts only if SCL still holds its new level
    assign rise_ok = scl_rise & scl_f;
    assign fall_ok = scl_fall & ~scl_f;

    // Open-drain: pull low or float; reset floats it at once
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Protocol FSM, shifters and SDA driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_shift  <= '0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (bus_start) begin
                start_det <= 1'b1;
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (bus_stop) begin
                stop_det <= 1'b1;
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    ST_ADDR: begin
                        if (rise_ok) begin
                            shift <= {shift[5:0], sda_f};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (shift == own_addr) begin
                                    rw    <= sda_f;
                                    busy  <= 1'b1;
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (rise_ok && bit_cnt == 4'd1 && rw) begin
                            tx_req <= 1'b1;
                        end
                        if (fall_ok) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe  <= 1'b1;
                                bit_cnt <= 4'd1;
                            end else if (rw) begin
                                tx_shift <= tx_data[6:0];
                                sda_oe   <= ~tx_data[7];
                                bit_cnt  <= 4'd1;
                                state    <= ST_READ;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (rise_ok && bit_cnt != 4'd8) begin
                            shift <= {shift[5:0], sda_f};
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shift, sda_f};
                                rx_valid <= 1'b1;
                            end
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (fall_ok && bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_WRITE_ACK;
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (fall_ok) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (fall_ok) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= ST_READ_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (rise_ok) begin
                            if (!sda_f) begin
                                tx_req <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_WAIT_STOP;
                            end
                        end else if (fall_ok) begin
                            tx_shift <= tx_data[6:0];
                            sda_oe   <= ~tx_data[7];
                            bit_cnt  <= 4'd1;
                            state    <= ST_READ;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged host plus transaction-level model.
// Glitch expectation follows I2C_TARGET_GLITCH_FILTER_EN.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_scl = 1'b1;
    logic       host_sda = 1'b1;
    logic [6:0] own_addr = 7'h48;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       rw;
    logic       start_det;
    logic       stop_det;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);
    assign scl = host_scl ? 1'bz : 1'b0;
    assign sda = host_sda ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_target #(.FILTER_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .own_addr (own_addr),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy),
        .rw       (rw),
        .start_det(start_det),
        .stop_det (stop_det),
        .scl      (scl),
        .sda      (sda)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_start, n_stop, n_txreq, n_drive;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] data[4];
    bit silent = 1'b0;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Per-cycle observer: pulse counts, rx capture, tx feed, stray drive
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_det) n_start++;
            if (stop_det) n_stop++;
            if (rx_valid) rxq.push_back(rx_data);
            if (tx_req) begin
                n_txreq++;
                if (txq.size() > 0) tx_data = txq.pop_front();
            end
            if (silent && host_sda && sda === 1'b0) n_drive++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        host_sda = 1'b1; tick(Q);
        host_scl = 1'b1; tick(Q);
        host_sda = 1'b0; tick(Q);
        host_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        host_sda = 1'b0; tick(Q);
        host_scl = 1'b1; tick(Q);
        host_sda = 1'b1; tick(Q);
    endtask

    task automatic wr_bit(input logic b);
        host_sda = b;    tick(Q);
        host_scl = 1'b1; tick(2 * Q);
        host_scl = 1'b0; tick(Q);
    endtask

    task automatic rd_bit(output logic b);
        host_sda = 1'b1; tick(Q);
        host_scl = 1'b1; tick(Q);
        b = sda;         tick(Q);
        host_scl = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    endtask

    task automatic rd_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
    endtask

    // One host transaction; expectations from address match and direction
    task automatic txn(input logic [6:0] a, input bit rd, input int n,
                       input bit stop_after, input string tag);
        bit match;
        logic b;
        logic [7:0] d;
        int exp_rx;
        match = (a == own_addr);
        n_start = 0; n_stop = 0; n_txreq = 0; n_drive = 0;
        rxq.delete();
        silent = !match;
        txq.delete();
        if (rd) for (int i = 0; i < n; i++) txq.push_back(data[i]);
        bus_start();
        wr_byte({a, rd});
        rd_bit(b);
        check({tag, " addr_ack"}, b, match ? 0 : 1);
        check({tag, " busy_addr"}, busy, match ? 1 : 0);
        if (match) check({tag, " rw"}, rw, rd);
        if (!rd) begin
            for (int i = 0; i < n; i++) begin
                wr_byte(data[i]);
                rd_bit(b);
                check({tag, " data_ack"}, b, match ? 0 : 1);
            end
        end else if (match) begin
            for (int i = 0; i < n; i++) begin
                rd_byte(d);
                check({tag, " rd_byte"}, d, data[i]);
                wr_bit(i == n - 1);
            end
            check({tag, " busy_nack"}, busy, 0);
        end
        if (stop_after) begin
            bus_stop();
            tick(Q);
            check({tag, " stop_cnt"}, n_stop, 1);
            check({tag, " busy_stop"}, busy, 0);
        end
        exp_rx = (match && !rd) ? n : 0;
        check({tag, " start_cnt"}, n_start, 1);
        check({tag, " rx_cnt"}, rxq.size(), exp_rx);
        for (int i = 0; i < exp_rx; i++)
            check({tag, " rx_byte"},
                  (i < rxq.size()) ? rxq[i] : 8'hxx, data[i]);
        check({tag, " txreq_cnt"}, n_txreq, (match && rd) ? n : 0);
        check({tag, " stray_drive"}, n_drive, 0);
        silent = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic b;
        logic [6:0] a;
        bit m, rd;
        int n;

        tick(4);
        check("reset outs",
              {rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det},
              0);
        check("reset sda", sda, 1);
        rst_n = 1'b1;
        tick(4);

        own_addr = 7'h48;
        data[0] = 8'hA5;
        txn(7'h48, 1'b0, 1, 1'b1, "write");
        check("write rx_data", rx_data, 8'hA5);
        check("write rw", rw, 0);

        data[0] = 8'h11;
        txn(7'h49, 1'b0, 1, 1'b1, "mismatch");

        data[0] = 8'h3C;
        data[1] = 8'hC3;
        txn(7'h48, 1'b1, 2, 1'b1, "read2");

        data[0] = 8'h07;
        txn(7'h48, 1'b0, 1, 1'b0, "rs_wr");
        data[0] = 8'h96;
        txn(7'h48, 1'b1, 1, 1'b1, "rs_rd");
        check("rs rx_data", rx_data, 8'h07);
        check("rs rw", rw, 1);

        txq.delete();
        txq.push_back(8'h0F);
        bus_start();
        wr_byte(8'h91);
        rd_bit(b);
        check("rst addr_ack", b, 0);
        for (int i = 0; i < 3; i++) rd_bit(b);
        host_sda = 1'b1; tick(Q);
        host_scl = 1'b1; tick(Q);
        check("rst pre drive", sda, 0);
        rst_n = 1'b0;
        #1;
        check("rst sda", sda, 1);
        check("rst outs",
              {rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det},
              0);
        tick(2);
        rst_n = 1'b1;
        tick(Q);
        host_scl = 1'b0; tick(Q);
        bus_stop();
        tick(Q);
        data[0] = 8'h5E;
        data[1] = 8'h21;
        txn(7'h48, 1'b0, 2, 1'b1, "post_rst");

        tick(Q);
        n_start = 0;
        n_stop = 0;
        @(negedge clk) host_sda = 1'b0;
        @(negedge clk) host_sda = 1'b1;
        tick(4 * Q);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("glitch start", n_start, 0);
`else
        check("glitch start", n_start, 1);
`endif

        for (int t = 0; t < 16; t++) begin
            own_addr = 7'($urandom_range(8, 119));
            m = ($urandom_range(0, 3) != 0);
            a = m ? own_addr
                  : own_addr ^ 7'($urandom_range(1, 127));
            rd = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
            txn(a, rd, n, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
